// File: rtl/mips_lite_pkg.sv
// Shared encodings for the MIPS-lite multicycle controller: opcodes, FSM states and
// datapath select codes.
package mips_lite_pkg;

  localparam logic [5:0] OP_R    = 6'b000000;
  localparam logic [5:0] OP_LW   = 6'b100011;
  localparam logic [5:0] OP_SW   = 6'b101011;
  localparam logic [5:0] OP_BEQ  = 6'b000100;
  localparam logic [5:0] OP_NORI = 6'b001101;
  localparam logic [5:0] OP_J    = 6'b000010;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_FETCH  = 4'd1,
    ST_DECODE = 4'd2,
    ST_MEMADR = 4'd3,
    ST_MEMRD  = 4'd4,
    ST_MEMWB  = 4'd5,
    ST_MEMWR  = 4'd6,
    ST_EXEC   = 4'd7,
    ST_RWB    = 4'd8,
    ST_NEXEC  = 4'd9,
    ST_NWB    = 4'd10,
    ST_BRANCH = 4'd11,
    ST_JUMP   = 4'd12,
    ST_TRAP   = 4'd13
  } state_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;
  localparam logic [1:0] ALUOP_NORI  = 2'b11;

  localparam logic [1:0] SRCB_REGB    = 2'b00;
  localparam logic [1:0] SRCB_FOUR    = 2'b01;
  localparam logic [1:0] SRCB_IMM     = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH2 = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // States that wait on the memory handshake and are subject to the timeout.
  function automatic logic is_mem_state(input state_t s);
    return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
  endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Counts consecutive stalled memory cycles; o_expired flags the stall cycle that hits the limit.
// Clear has priority over enable; the count saturates at all-ones.
module mem_wait_timer #(
  parameter int WAIT_LIMIT = 15,
  parameter int WCNT_W     = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  logic [WCNT_W-1:0] r_cnt;
  logic              w_sat;

  assign w_sat = &r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clear) begin
      r_cnt <= '0;
    end else if (i_enable && !w_sat) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // The current stall is the WAIT_LIMIT-th when WAIT_LIMIT-1 stalls are already counted.
  assign o_expired = i_enable && (r_cnt == WCNT_W'(WAIT_LIMIT - 1));

endmodule

// File: rtl/multicycle_control.sv
// Moore sequencer for the multicycle MIPS-lite datapath; outputs decode from state (plus mem_ready).
// Memory states hold until mem_ready; too many consecutive stalls or an illegal opcode lock into TRAP.
module multicycle_control
  import mips_lite_pkg::*;
#(
  parameter int WAIT_LIMIT = 15,
  parameter int WCNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] opcode,
  input  logic       mem_ready,
  output logic       pcwrite,
  output logic       pcwritecond,
  output logic       iord,
  output logic       memread,
  output logic       memwrite,
  output logic       memtoreg,
  output logic       irwrite,
  output logic       regdest,
  output logic       regwrite,
  output logic       alusrca,
  output logic [1:0] alusrcb,
  output logic [1:0] aluop,
  output logic [1:0] pcsource,
  output logic       instr_done,
  output logic       trap
);

  state_t r_state;
  state_t w_next;
  logic   w_stall;
  logic   w_expired;
  logic   w_clear;

  assign w_stall = is_mem_state(r_state) && !mem_ready;
  assign w_clear = (w_next != r_state);

  mem_wait_timer #(
    .WAIT_LIMIT(WAIT_LIMIT),
    .WCNT_W    (WCNT_W)
  ) u_timer (
    .clk      (clk),
    .rst_n    (rst_n),
    .i_clear  (w_clear),
    .i_enable (w_stall),
    .o_expired(w_expired)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // mem_ready is tested before the timeout so a ready in the limit cycle still completes.
  always_comb begin
    w_next = ST_TRAP;
    case (r_state)
      ST_IDLE:   w_next = ST_FETCH;
      ST_FETCH: begin
        if (mem_ready)      w_next = ST_DECODE;
        else if (w_expired) w_next = ST_TRAP;
        else                w_next = ST_FETCH;
      end
      ST_DECODE: begin
        case (opcode)
          OP_LW, OP_SW: w_next = ST_MEMADR;
          OP_R:         w_next = ST_EXEC;
          OP_NORI:      w_next = ST_NEXEC;
          OP_BEQ:       w_next = ST_BRANCH;
          OP_J:         w_next = ST_JUMP;
          default:      w_next = ST_TRAP;
        endcase
      end
      ST_MEMADR: begin
        if (opcode == OP_LW)      w_next = ST_MEMRD;
        else if (opcode == OP_SW) w_next = ST_MEMWR;
        else                      w_next = ST_TRAP;
      end
      ST_MEMRD: begin
        if (mem_ready)      w_next = ST_MEMWB;
        else if (w_expired) w_next = ST_TRAP;
        else                w_next = ST_MEMRD;
      end
      ST_MEMWR: begin
        if (mem_ready)      w_next = ST_FETCH;
        else if (w_expired) w_next = ST_TRAP;
        else                w_next = ST_MEMWR;
      end
      ST_EXEC:   w_next = ST_RWB;
      ST_NEXEC:  w_next = ST_NWB;
      ST_MEMWB,
      ST_RWB,
      ST_NWB,
      ST_BRANCH,
      ST_JUMP:   w_next = ST_FETCH;
      ST_TRAP:   w_next = ST_TRAP;
      default:   w_next = ST_TRAP;
    endcase
  end

  always_comb begin
    pcwrite     = 1'b0;
    pcwritecond = 1'b0;
    iord        = 1'b0;
    memread     = 1'b0;
    memwrite    = 1'b0;
    memtoreg    = 1'b0;
    irwrite     = 1'b0;
    regdest     = 1'b0;
    regwrite    = 1'b0;
    alusrca     = 1'b0;
    alusrcb     = SRCB_REGB;
    aluop       = ALUOP_ADD;
    pcsource    = PCSRC_ALU;
    instr_done  = 1'b0;
    trap        = 1'b0;
    case (r_state)
      ST_FETCH: begin
        memread  = 1'b1;
        alusrcb  = SRCB_FOUR;
        aluop    = ALUOP_ADD;
        pcsource = PCSRC_ALU;
        irwrite  = mem_ready;
        pcwrite  = mem_ready;
      end
      ST_DECODE: begin
        alusrcb = SRCB_IMM_SH2;
        aluop   = ALUOP_ADD;
      end
      ST_MEMADR: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_ADD;
      end
      ST_MEMRD: begin
        memread = 1'b1;
        iord    = 1'b1;
      end
      ST_MEMWB: begin
        regwrite   = 1'b1;
        memtoreg   = 1'b1;
        instr_done = 1'b1;
      end
      ST_MEMWR: begin
        memwrite   = 1'b1;
        iord       = 1'b1;
        instr_done = mem_ready;
      end
      ST_EXEC: begin
        alusrca = 1'b1;
        aluop   = ALUOP_FUNCT;
      end
      ST_RWB: begin
        regdest    = 1'b1;
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      ST_NEXEC: begin
        alusrca = 1'b1;
        alusrcb = SRCB_IMM;
        aluop   = ALUOP_NORI;
      end
      ST_NWB: begin
        regwrite   = 1'b1;
        instr_done = 1'b1;
      end
      ST_BRANCH: begin
        alusrca     = 1'b1;
        aluop       = ALUOP_SUB;
        pcwritecond = 1'b1;
        pcsource    = PCSRC_ALUOUT;
        instr_done  = 1'b1;
      end
      ST_JUMP: begin
        pcwrite    = 1'b1;
        pcsource   = PCSRC_JUMP;
        instr_done = 1'b1;
      end
      ST_TRAP:  trap = 1'b1;
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: directed vector table, hand-written reset/timeout
// sequences and randomized instruction streams checked against a per-instruction step model.
module tb_multicycle_control;

  localparam int WAIT_LIMIT = 15;

  localparam logic [5:0] T_R    = 6'b000000;
  localparam logic [5:0] T_LW   = 6'b100011;
  localparam logic [5:0] T_SW   = 6'b101011;
  localparam logic [5:0] T_BEQ  = 6'b000100;
  localparam logic [5:0] T_NORI = 6'b001101;
  localparam logic [5:0] T_J    = 6'b000010;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       mem_ready = 1'b0;
  logic       pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite;
  logic       regdest, regwrite, alusrca, instr_done, trap;
  logic [1:0] alusrcb, aluop, pcsource;

  always #5 clk = ~clk;

  multicycle_control #(.WAIT_LIMIT(WAIT_LIMIT), .WCNT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
    .pcwrite(pcwrite), .pcwritecond(pcwritecond), .iord(iord), .memread(memread),
    .memwrite(memwrite), .memtoreg(memtoreg), .irwrite(irwrite), .regdest(regdest),
    .regwrite(regwrite), .alusrca(alusrca), .alusrcb(alusrcb), .aluop(aluop),
    .pcsource(pcsource), .instr_done(instr_done), .trap(trap)
  );

  logic [17:0] w_ctl;
  assign w_ctl = {pcwrite, pcwritecond, iord, memread, memwrite, memtoreg, irwrite,
                  regdest, regwrite, alusrca, alusrcb, aluop, pcsource, instr_done, trap};

  function automatic logic [17:0] mk(input bit pcw, input bit pcwc, input bit io,
                                     input bit mr, input bit mw, input bit m2r,
                                     input bit irw, input bit rd, input bit rw,
                                     input bit asa, input logic [1:0] asb,
                                     input logic [1:0] aop, input logic [1:0] psrc,
                                     input bit done, input bit tr);
    return {pcw, pcwc, io, mr, mw, m2r, irw, rd, rw, asa, asb, aop, psrc, done, tr};
  endfunction

  // Expected control words, written straight from the per-state output list.
  localparam logic [17:0] W_ZERO    = 18'd0;
  localparam logic [17:0] W_FETCH_S = mk(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0,0);
  localparam logic [17:0] W_FETCH_R = mk(1,0,0,1,0,0,1,0,0,0,2'b01,2'b00,2'b00,0,0);
  localparam logic [17:0] W_DECODE  = mk(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0,0);
  localparam logic [17:0] W_MEMADR  = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0,0);
  localparam logic [17:0] W_MEMRD   = mk(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [17:0] W_MEMWB   = mk(0,0,0,0,0,1,0,0,1,0,2'b00,2'b00,2'b00,1,0);
  localparam logic [17:0] W_MEMWR_S = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0,0);
  localparam logic [17:0] W_MEMWR_R = mk(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,1,0);
  localparam logic [17:0] W_EXEC    = mk(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0,0);
  localparam logic [17:0] W_RWB     = mk(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,1,0);
  localparam logic [17:0] W_NEXEC   = mk(0,0,0,0,0,0,0,0,0,1,2'b10,2'b11,2'b00,0,0);
  localparam logic [17:0] W_NWB     = mk(0,0,0,0,0,0,0,0,1,0,2'b00,2'b00,2'b00,1,0);
  localparam logic [17:0] W_BRANCH  = mk(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,1,0);
  localparam logic [17:0] W_JUMP    = mk(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,1,0);
  localparam logic [17:0] W_TRAP    = mk(0,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b00,0,1);

  int n_cmp = 0;
  int n_bad = 0;
  int g_cyc = 0;
  int g_done_at = 0;

  task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // One clock: drive mem_ready after the falling edge, sample before the next rising edge.
  task automatic cyc(input bit rdy, input logic [17:0] exp, input string nm);
    @(negedge clk);
    mem_ready = rdy;
    #2;
    g_cyc++;
    if (instr_done === 1'b1 && g_done_at == 0) g_done_at = g_cyc;
    check(nm, {14'd0, w_ctl}, {14'd0, exp});
  endtask

  function automatic bit rnd_bit();
    return bit'($urandom_range(0, 1));
  endfunction

  // A memory phase of 'waits' stalls: stalls up to the limit, then either a ready cycle or TRAP.
  task automatic mem_phase(input int waits, input logic [17:0] ws, input logic [17:0] wr,
                           input string nm, output bit trapped);
    trapped = 1'b0;
    for (int i = 0; i < waits && i < WAIT_LIMIT; i++) cyc(1'b0, ws, nm);
    if (waits >= WAIT_LIMIT) trapped = 1'b1;
    else cyc(1'b1, wr, nm);
  endtask

  task automatic run_instr(input logic [5:0] op, input int wf, input int wm, output bit trapped);
    opcode = op;
    mem_phase(wf, W_FETCH_S, W_FETCH_R, "fetch", trapped);
    if (!trapped) begin
      cyc(rnd_bit(), W_DECODE, "decode");
      case (op)
        T_LW: begin
          cyc(rnd_bit(), W_MEMADR, "lw_memadr");
          mem_phase(wm, W_MEMRD, W_MEMRD, "lw_memrd", trapped);
          if (!trapped) cyc(rnd_bit(), W_MEMWB, "lw_memwb");
        end
        T_SW: begin
          cyc(rnd_bit(), W_MEMADR, "sw_memadr");
          mem_phase(wm, W_MEMWR_S, W_MEMWR_R, "sw_memwr", trapped);
        end
        T_R: begin
          cyc(rnd_bit(), W_EXEC, "r_exec");
          cyc(rnd_bit(), W_RWB, "r_wb");
        end
        T_NORI: begin
          cyc(rnd_bit(), W_NEXEC, "nori_exec");
          cyc(rnd_bit(), W_NWB, "nori_wb");
        end
        T_BEQ:   cyc(rnd_bit(), W_BRANCH, "beq");
        T_J:     cyc(rnd_bit(), W_JUMP, "jump");
        default: trapped = 1'b1;
      endcase
    end
  endtask

  // Checks the state just before reset, that outputs drop without a clock edge, then IDLE.
  task automatic do_reset(input logic [17:0] pre_exp, input string nm);
    @(negedge clk);
    #2;
    check({nm, "_pre"}, {14'd0, w_ctl}, {14'd0, pre_exp});
    rst_n = 1'b0;
    #1;
    check({nm, "_async"}, {14'd0, w_ctl}, 32'd0);
    @(negedge clk);
    #1;
    check({nm, "_hold"}, {14'd0, w_ctl}, 32'd0);
    rst_n = 1'b1;
    #1;
    check({nm, "_idle"}, {14'd0, w_ctl}, 32'd0);
  endtask

  function automatic int rnd_wait();
    if ($urandom_range(0, 99) < 85) return int'($urandom_range(0, 3));
    return int'($urandom_range(12, 16));
  endfunction

  typedef struct {
    logic [5:0] op;
    int         wf;
    int         wm;
    int         exp_done;
    bit         exp_trap;
    string      nm;
  } vec_t;

  vec_t tbl[$];
  logic [5:0] legal_ops[6];

  initial begin
    bit tr;
    logic [5:0] op;

    tbl.push_back('{T_LW,   0,  0,  5, 1'b0, "lw_0wait"});
    tbl.push_back('{T_SW,   0,  0,  4, 1'b0, "sw_0wait"});
    tbl.push_back('{T_R,    0,  0,  4, 1'b0, "r_0wait"});
    tbl.push_back('{T_NORI, 0,  0,  4, 1'b0, "nori_0wait"});
    tbl.push_back('{T_BEQ,  0,  0,  3, 1'b0, "beq_0wait"});
    tbl.push_back('{T_J,    0,  0,  3, 1'b0, "j_0wait"});
    tbl.push_back('{T_LW,   3,  0,  8, 1'b0, "lw_fetch3"});
    tbl.push_back('{T_SW,   0,  2,  6, 1'b0, "sw_mem2"});
    tbl.push_back('{T_LW,   0, 14, 19, 1'b0, "lw_mem14"});
    tbl.push_back('{T_BEQ, 14,  0, 17, 1'b0, "beq_fetch14"});
    tbl.push_back('{T_LW,   0, 15,  0, 1'b1, "lw_mem15"});
    tbl.push_back('{T_SW,   1, 15,  0, 1'b1, "sw_mem15"});
    tbl.push_back('{T_R,   15,  0,  0, 1'b1, "fetch15"});
    tbl.push_back('{6'h3f,  0,  0,  0, 1'b1, "illegal_3f"});
    tbl.push_back('{6'h01,  2,  0,  0, 1'b1, "illegal_01"});

    legal_ops = '{T_R, T_LW, T_SW, T_BEQ, T_NORI, T_J};

    do_reset(W_ZERO, "por");

    foreach (tbl[k]) begin
      g_cyc = 0;
      g_done_at = 0;
      run_instr(tbl[k].op, tbl[k].wf, tbl[k].wm, tr);
      if (tr) begin
        for (int i = 0; i < 20; i++) cyc(rnd_bit(), W_TRAP, {tbl[k].nm, "_trap_hold"});
      end
      check({tbl[k].nm, "_done_cycle"}, 32'(g_done_at), 32'(tbl[k].exp_done));
      check({tbl[k].nm, "_trap"}, {31'd0, trap}, {31'd0, tbl[k].exp_trap});
      if (tr) do_reset(W_TRAP, {tbl[k].nm, "_rst"});
    end

    // Reset dropped while a load is stalled in its memory read.
    opcode = T_LW;
    cyc(1'b1, W_FETCH_R, "mid_fetch");
    cyc(1'b0, W_DECODE, "mid_decode");
    cyc(1'b0, W_MEMADR, "mid_memadr");
    for (int i = 0; i < 3; i++) cyc(1'b0, W_MEMRD, "mid_memrd");
    do_reset(W_MEMRD, "mid_rst");
    g_cyc = 0;
    g_done_at = 0;
    run_instr(T_LW, 0, 0, tr);
    check("after_mid_rst_done_cycle", 32'(g_done_at), 32'd5);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 9) == 0) op = 6'($urandom_range(0, 63));
      else op = legal_ops[$urandom_range(0, 5)];
      run_instr(op, rnd_wait(), rnd_wait(), tr);
      if (tr) begin
        for (int i = 0; i < 3; i++) cyc(rnd_bit(), W_TRAP, "rnd_trap_hold");
        do_reset(W_TRAP, "rnd_rst");
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
